// File: rtl/uart_rx_if.sv
// Port bundle between the UART receiver and its consumer: serial line, baud select, word handshake.
// Latency: none, wiring only.
// Backpressure: VALIDo is held until ACKi; words completed meanwhile are dropped and flagged via OVERRUNo.
interface uart_rx_if #(
    parameter int DATA_WDTH = 8
);
    logic                 RXi;
    logic [31:0]          BAUD_RATEi;
    logic                 ACKi;
    logic [DATA_WDTH-1:0] DATAo;
    logic                 VALIDo;
    logic                 FRAME_ERRo;
    logic                 PAR_ERRo;
    logic                 OVERRUNo;
    logic                 BUSYo;

    // receiver side
    modport master (
        input  RXi, BAUD_RATEi, ACKi,
        output DATAo, VALIDo, FRAME_ERRo, PAR_ERRo, OVERRUNo, BUSYo
    );

    // line driver / word consumer side
    modport slave (
        output RXi, BAUD_RATEi, ACKi,
        input  DATAo, VALIDo, FRAME_ERRo, PAR_ERRo, OVERRUNo, BUSYo
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start/LSB-first data/[parity]/stop framing, mid-bit sampling; PARITY_EN macro adds even parity.
// Latency: VALIDo rises 1 clock after the stop-bit sample (2-flop RXi synchronizer ahead of the FSM).
// Backpressure: word held until ACKi; a frame completing while VALIDo is high is dropped and sets sticky OVERRUNo.
module uart_rx #(
    parameter int FREQ_CLK  = 100000000,
    parameter int DATA_WDTH = 8
) (
    input  logic      CLKip,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int                 IDX_W     = (DATA_WDTH > 1) ? $clog2(DATA_WDTH) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_WDTH - 1);
    localparam logic [31:0]        FREQ_U    = 32'(FREQ_CLK);
    localparam logic [31:0]        DFLT_BAUD = 32'd115200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta, rx_s, rx_prev;
    logic [31:0]           cnt_q;
    logic [31:0]           period_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WDTH-1:0]  shreg_q;
    logic [DATA_WDTH-1:0]  data_q;
    logic                  valid_q, ferr_q, perr_q, ovr_q;
    logic                  par_err_new;

    // control strobes decoded from the state
    logic                  busy, load_period, cnt_clr, data_smp, frame_done;

    logic                  fall, half_hit, bit_hit;
    logic [31:0]           baud_sel, period_new;

    assign fall       = rx_prev & ~rx_s;
    assign half_hit   = (cnt_q == (period_q >> 1));
    assign bit_hit    = (cnt_q == (period_q - 32'd1));
    assign baud_sel   = (bus.BAUD_RATEi == 32'd0) ? DFLT_BAUD : bus.BAUD_RATEi;
    // +1 matches the transmitter's strobe spacing
    assign period_new = FREQ_U / baud_sel + 32'd1;

`ifdef PARITY_EN
    logic par_q;
    logic par_smp;
    assign par_err_new = (^shreg_q) ^ par_q;
`else
    assign par_err_new = 1'b0;
`endif

    // two-flop synchronizer on the async line plus one delay stage for edge detection
    always_ff @(posedge CLKip or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.RXi;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // FSM state register
    always_ff @(posedge CLKip or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fall) state_d = S_START;
            S_START:  if (half_hit) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (bit_hit && (idx_q == LAST_IDX))
`ifdef PARITY_EN
                          state_d = S_PARITY;
            S_PARITY: if (bit_hit) state_d = S_STOP;
`else
                          state_d = S_STOP;
`endif
            S_STOP:   if (bit_hit) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM output decode: counter control and sampling strobes
    always_comb begin
        busy        = 1'b1;
        load_period = 1'b0;
        cnt_clr     = 1'b0;
        data_smp    = 1'b0;
        frame_done  = 1'b0;
`ifdef PARITY_EN
        par_smp     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                busy        = 1'b0;
                load_period = fall;
                cnt_clr     = 1'b1;
            end
            S_START:  cnt_clr = half_hit;
            S_DATA: begin
                cnt_clr  = bit_hit;
                data_smp = bit_hit;
            end
`ifdef PARITY_EN
            S_PARITY: begin
                cnt_clr = bit_hit;
                par_smp = bit_hit;
            end
`endif
            S_STOP: begin
                cnt_clr    = bit_hit;
                frame_done = bit_hit;
            end
            default: busy = 1'b0;
        endcase
    end

    // bit-period counter, bit index, baud latch and shift register; counters stay at 0 in IDLE
    always_ff @(posedge CLKip or posedge rst) begin
        if (rst) begin
            cnt_q    <= 32'd0;
            period_q <= 32'd0;
            idx_q    <= '0;
            shreg_q  <= '0;
        end else begin
            cnt_q <= cnt_clr ? 32'd0 : cnt_q + 32'd1;
            if (load_period) begin
                period_q <= period_new;
                shreg_q  <= '0;
            end
            if (state_q == S_IDLE) begin
                idx_q <= '0;
            end else if (data_smp) begin
                shreg_q[idx_q] <= rx_s;
                idx_q          <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

`ifdef PARITY_EN
    // parity bit capture
    always_ff @(posedge CLKip or posedge rst) begin
        if (rst)          par_q <= 1'b0;
        else if (par_smp) par_q <= rx_s;
    end
`endif

    // word handshake: load on completion, drop and flag overrun if the previous word is still unacked
    always_ff @(posedge CLKip or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (frame_done) begin
            if (!valid_q || bus.ACKi) begin
                data_q  <= shreg_q;
                ferr_q  <= ~rx_s;
                perr_q  <= par_err_new;
                valid_q <= 1'b1;
                ovr_q   <= 1'b0;
            end else begin
                ovr_q   <= 1'b1;
            end
        end else if (bus.ACKi && valid_q) begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign bus.DATAo      = data_q;
    assign bus.VALIDo     = valid_q;
    assign bus.FRAME_ERRo = ferr_q;
    assign bus.PAR_ERRo   = perr_q;
    assign bus.OVERRUNo   = ovr_q;
    assign bus.BUSYo      = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames bit by bit, checks the word handshake and flags.
// Latency: frames are timed in whole bit periods; outputs sampled on the falling clock edge.
// Backpressure: exercises held VALIDo, overrun, and ack coinciding with frame completion.
module tb_uart_rx;
    localparam int P_FAST = 11;   // 100 MHz / 10 Mbaud + 1
    localparam int P_DFLT = 869;  // 100 MHz / 115200 + 1
`ifdef PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // negedge index (from start-bit drive) at which ACKi must be high to meet the completion cycle
    localparam int ACK_AT = 3 + P_FAST / 2 + NB * P_FAST;

    logic CLKip = 1'b0;
    logic rst;
    always #5 CLKip = ~CLKip;

    uart_rx_if #(.DATA_WDTH(8)) bus ();

    uart_rx #(.FREQ_CLK(100000000), .DATA_WDTH(8)) dut (
        .CLKip (CLKip),
        .rst   (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_valid = 1'b0, prev_busy = 1'b0;
    logic rise_seen, busy_at_rise, busy_before, valid_dropped;
    int busy_run = 0, max_busy_run = 0;

    task automatic observe();
        if (bus.VALIDo && !prev_valid) begin
            rise_seen    = 1'b1;
            busy_at_rise = bus.BUSYo;
            busy_before  = prev_busy;
        end
        if (!bus.VALIDo && prev_valid) valid_dropped = 1'b1;
        if (bus.BUSYo) begin
            busy_run++;
            if (busy_run > max_busy_run) max_busy_run = busy_run;
        end else begin
            busy_run = 0;
        end
        prev_valid = bus.VALIDo;
        prev_busy  = bus.BUSYo;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLKip);
            observe();
        end
    endtask

    task automatic send_bit(input logic b, input int p, input int ack_at);
        bus.RXi = b;
        repeat (p) begin
            @(negedge CLKip);
            cyc++;
            if (cyc == ack_at) bus.ACKi = 1'b1;
            else if (cyc == ack_at + 1) bus.ACKi = 1'b0;
            observe();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input int p, input int ack_at);
        cyc = 0;
        send_bit(1'b0, p, ack_at);
        for (int i = 0; i < 8; i++) send_bit(d[i], p, ack_at);
`ifdef PARITY_EN
        send_bit((^d) ^ par_flip, p, ack_at);
`endif
        send_bit(stop, p, ack_at);
        bus.RXi = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.ACKi = 1'b1;
        @(negedge CLKip);
        observe();
        bus.ACKi = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.VALIDo !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.VALIDo); end
        checks++; if (bus.DATAo !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.DATAo); end
        checks++; if (bus.FRAME_ERRo !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.FRAME_ERRo); end
        checks++; if (bus.PAR_ERRo !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", bus.PAR_ERRo); end
        checks++; if (bus.OVERRUNo !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", bus.OVERRUNo); end
        checks++; if (bus.BUSYo !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSYo); end
    endtask

    task automatic test_basic();
        rise_seen = 1'b0; busy_at_rise = 1'b1; busy_before = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, P_FAST, -1);
        idle(4);
        checks++; if (bus.VALIDo !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.VALIDo); end
        checks++; if (bus.DATAo !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", bus.DATAo); end
        checks++; if (bus.FRAME_ERRo !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", bus.FRAME_ERRo); end
        checks++; if (bus.PAR_ERRo !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b expected 0", bus.PAR_ERRo); end
        checks++; if (rise_seen !== 1'b1) begin errors++; $display("FAIL basic_rise_seen: got %b expected 1", rise_seen); end
        checks++; if (busy_at_rise !== 1'b0) begin errors++; $display("FAIL basic_busy_at_rise: got %b expected 0", busy_at_rise); end
        checks++; if (busy_before !== 1'b1) begin errors++; $display("FAIL basic_busy_before_rise: got %b expected 1", busy_before); end
        ack_pulse();
        checks++; if (bus.VALIDo !== 1'b0) begin errors++; $display("FAIL basic_ack_valid: got %b expected 0", bus.VALIDo); end
        idle(4);
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, P_FAST, -1);
        idle(4);
        checks++; if (bus.VALIDo !== 1'b1) begin errors++; $display("FAIL ferr_valid: got %b expected 1", bus.VALIDo); end
        checks++; if (bus.DATAo !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", bus.DATAo); end
        checks++; if (bus.FRAME_ERRo !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", bus.FRAME_ERRo); end
        ack_pulse();
        checks++; if (bus.FRAME_ERRo !== 1'b0) begin errors++; $display("FAIL ferr_ack_clear: got %b expected 0", bus.FRAME_ERRo); end
        idle(4);
    endtask

    task automatic test_glitch();
        busy_run = 0; max_busy_run = 0;
        bus.RXi = 1'b0;
        idle(3);
        bus.RXi = 1'b1;
        idle(20);
        checks++; if (bus.VALIDo !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", bus.VALIDo); end
        checks++; if (bus.BUSYo !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", bus.BUSYo); end
        checks++; if (max_busy_run < 1 || max_busy_run > 6) begin errors++; $display("FAIL glitch_busy_len: got %0d expected 1..6", max_busy_run); end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 1'b0, P_FAST, -1);
        idle(4);
        send_frame(8'h22, 1'b1, 1'b0, P_FAST, -1);
        idle(4);
        checks++; if (bus.VALIDo !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus.VALIDo); end
        checks++; if (bus.DATAo !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", bus.DATAo); end
        checks++; if (bus.OVERRUNo !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", bus.OVERRUNo); end
        ack_pulse();
        checks++; if (bus.VALIDo !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid: got %b expected 0", bus.VALIDo); end
        checks++; if (bus.OVERRUNo !== 1'b0) begin errors++; $display("FAIL ovr_ack_flag: got %b expected 0", bus.OVERRUNo); end
        checks++; if (bus.FRAME_ERRo !== 1'b0 || bus.PAR_ERRo !== 1'b0) begin errors++; $display("FAIL ovr_ack_errs: got ferr=%b perr=%b expected 0 0", bus.FRAME_ERRo, bus.PAR_ERRo); end
        idle(4);
    endtask

    task automatic test_ack_same_cycle();
        send_frame(8'h33, 1'b1, 1'b0, P_FAST, -1);
        idle(4);
        valid_dropped = 1'b0;
        send_frame(8'h44, 1'b1, 1'b0, P_FAST, ACK_AT);
        idle(4);
        checks++; if (valid_dropped !== 1'b0) begin errors++; $display("FAIL samecyc_valid_dropped: got %b expected 0", valid_dropped); end
        checks++; if (bus.DATAo !== 8'h44) begin errors++; $display("FAIL samecyc_data: got %h expected 44", bus.DATAo); end
        checks++; if (bus.OVERRUNo !== 1'b0) begin errors++; $display("FAIL samecyc_ovr: got %b expected 0", bus.OVERRUNo); end
        ack_pulse();
        idle(4);
    endtask

    task automatic test_default_baud();
        bus.BAUD_RATEi = 32'd0;
        send_frame(8'hFF, 1'b1, 1'b0, P_DFLT, -1);
        idle(4);
        checks++; if (bus.VALIDo !== 1'b1) begin errors++; $display("FAIL dflt_valid: got %b expected 1", bus.VALIDo); end
        checks++; if (bus.DATAo !== 8'hFF) begin errors++; $display("FAIL dflt_data: got %h expected ff", bus.DATAo); end
        checks++; if (bus.FRAME_ERRo !== 1'b0) begin errors++; $display("FAIL dflt_ferr: got %b expected 0", bus.FRAME_ERRo); end
        ack_pulse();
        bus.BAUD_RATEi = 32'd10000000;
        idle(4);
    endtask

    task automatic test_parity();
`ifdef PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, P_FAST, -1);  // parity bit 0
        idle(4);
        checks++; if (bus.PAR_ERRo !== 1'b1) begin errors++; $display("FAIL par_bad: got %b expected 1", bus.PAR_ERRo); end
        checks++; if (bus.DATAo !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h expected 07", bus.DATAo); end
        ack_pulse();
        idle(4);
        send_frame(8'h07, 1'b1, 1'b0, P_FAST, -1);  // parity bit 1
        idle(4);
        checks++; if (bus.PAR_ERRo !== 1'b0) begin errors++; $display("FAIL par_good: got %b expected 0", bus.PAR_ERRo); end
        checks++; if (bus.VALIDo !== 1'b1) begin errors++; $display("FAIL par_good_valid: got %b expected 1", bus.VALIDo); end
`else
        send_frame(8'h07, 1'b1, 1'b0, P_FAST, -1);
        idle(4);
        checks++; if (bus.PAR_ERRo !== 1'b0) begin errors++; $display("FAIL nopar_perr: got %b expected 0", bus.PAR_ERRo); end
        checks++; if (bus.DATAo !== 8'h07) begin errors++; $display("FAIL nopar_data: got %h expected 07", bus.DATAo); end
`endif
        ack_pulse();
        idle(4);
    endtask

    task automatic test_reset_mid();
        send_frame(8'h99, 1'b1, 1'b0, P_FAST, -1);  // leave a word pending
        idle(4);
        cyc = 0;
        send_bit(1'b0, P_FAST, -1);
        send_bit(1'b1, P_FAST, -1);
        send_bit(1'b0, P_FAST, -1);
        send_bit(1'b1, P_FAST, -1);
        rst = 1'b1;
        bus.RXi = 1'b1;
        idle(1);
        checks++; if (bus.VALIDo !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.VALIDo); end
        checks++; if (bus.DATAo !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", bus.DATAo); end
        checks++; if (bus.BUSYo !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.BUSYo); end
        idle(3);
        rst = 1'b0;
        idle(5);
        send_frame(8'h5A, 1'b1, 1'b0, P_FAST, -1);
        idle(4);
        checks++; if (bus.VALIDo !== 1'b1) begin errors++; $display("FAIL rstmid_next_valid: got %b expected 1", bus.VALIDo); end
        checks++; if (bus.DATAo !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h expected 5a", bus.DATAo); end
        checks++; if (bus.FRAME_ERRo !== 1'b0) begin errors++; $display("FAIL rstmid_next_ferr: got %b expected 0", bus.FRAME_ERRo); end
        ack_pulse();
        idle(4);
    endtask

    initial begin
        rst            = 1'b1;
        bus.RXi        = 1'b1;
        bus.ACKi       = 1'b0;
        bus.BAUD_RATEi = 32'd10000000;
        repeat (3) @(negedge CLKip);
        test_reset();
        rst = 1'b0;
        idle(5);
        test_basic();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_ack_same_cycle();
        test_default_baud();
        test_parity();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
